io_responder: RTL and testbench
===============================

IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 Parameter WIDTH, default 16, core data-path width in bits (matches `WIDTH).
REQ-002 Parameter TX_DEPTH, default 4, TX byte FIFO entries, power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 resetq  input  1  asynchronous, active-low reset.
REQ-005 io_rd  input  1  core IO read strobe, one cycle per request.
REQ-006 io_wr  input  1  core IO write strobe; the core holds it while io_ready is low.
REQ-007 io_addr  input  16  IO address.
REQ-008 io_dout  input  WIDTH  core write data.
REQ-009 io_din  output  WIDTH  registered read data returned to the core.
REQ-010 io_ready  output  1  combinational; low means the current io_wr is stalled.
REQ-011 leds  output  8  LED register.
REQ-012 tx_data  output  8  head of the TX FIFO.
REQ-013 tx_valid  output  1  TX FIFO not empty.
REQ-014 tx_ready  input  1  sink accepts tx_data when tx_valid and tx_ready are both high.
REQ-015 rx_data  input  8  received byte.
REQ-016 rx_valid  input  1  one-cycle pulse: rx_data is valid.

Function
REQ-017 Address map:
  - 0x1000 LED: read/write, bits 7:0.
  - 0x2000 write: push io_dout[7:0] into the TX FIFO.
  - 0x2000 read: return the RX byte, zero-extended, and clear rx_avail.
  - 0x2001 status, read only: bit0 tx_full, bit1 rx_avail, bit2 rx_overrun; other bits 0.
  - 0x4000 tick counter: read returns the count; write clears it to 0.
REQ-018 Read latency is one cycle: io_din SHALL be loaded on the edge that samples io_rd and SHALL hold its value until the next accepted read.
REQ-019 Reads of unmapped addresses SHALL return 0; writes to unmapped addresses SHALL be ignored.
REQ-020 A write SHALL be accepted in any cycle where io_wr and io_ready are both high.
REQ-021 io_ready SHALL be low only while io_wr targets 0x2000, the TX FIFO is full and no TX pop occurs in that cycle.
REQ-022 Full FIFO with a simultaneous pop and push: the push SHALL be accepted, occupancy stays at TX_DEPTH.
REQ-023 Empty FIFO with a push: tx_valid SHALL rise the next cycle; there is no fall-through.
REQ-024 Pointers SHALL wrap modulo TX_DEPTH; occupancy SHALL be tracked with a count of log2(TX_DEPTH)+1 bits.
REQ-025 rx_valid while rx_avail=1 and no RX read in the same cycle: the new byte SHALL overwrite the old one and rx_overrun SHALL be set.
REQ-026 rx_valid in the same cycle as an RX read: the read SHALL return the old byte, the new byte is latched, rx_avail stays 1, no overrun.
REQ-027 A status read SHALL return the pre-edge status and clear rx_overrun, unless an overrun occurs in that same cycle (set wins).
REQ-028 io_rd and io_wr both high in one cycle: the write SHALL execute, the read is ignored and io_din holds.
REQ-029 The tick counter SHALL increment every cycle, wrap from 2^WIDTH-1 to 0, and a clear write SHALL take priority over the increment.

Reset
REQ-030 On resetq low, these SHALL be forced asynchronously to 0: io_din, leds, the FIFO pointers and count, tx_valid, rx_avail, rx_overrun and the tick counter.
REQ-031 tx_data SHALL be don't-care while tx_valid=0.
REQ-032 Reset asserted mid-operation SHALL discard all FIFO contents and any pending RX byte.

Configuration
REQ-033 Macro IO_TICK_COUNTER_EN defined: the tick counter is implemented as in REQ-029.
REQ-034 Macro IO_TICK_COUNTER_EN undefined: no counter flops; reads of 0x4000 return 0 and writes to 0x4000 are ignored.

Structure
REQ-035 Package io_pkg SHALL hold the address constants, the status bit positions and the default TX_DEPTH.
REQ-036 Sub-module io_tx_fifo SHALL implement the TX FIFO: push/pop ports, full and empty flags, registered storage.

Verification
REQ-037 After reset: write 0x1000 with 0x00A5, then read 0x1000 -> leds=0xA5; io_din=0x00A5 one cycle after io_rd.
REQ-038 With tx_ready=0, write 0x41, 0x42, 0x43, 0x44, 0x45 to 0x2000 -> fifth write sees io_ready=0; raise tx_ready -> 0x41 drains, the fifth write is accepted, output order is 0x41..0x45.
REQ-039 Fill the FIFO, then push and pop in the same cycle -> no stall, count stays 4.
REQ-040 Two rx_valid pulses (0x11, then 0x22) without a read -> status=0x0006; read 0x2000 returns 0x0022; next status read returns 0x0000.
REQ-041 rx_valid(0x33) in the same cycle as a read of 0x2000 holding 0x22 -> read returns 0x0022; next read returns 0x0033; overrun stays 0.
REQ-042 With IO_TICK_COUNTER_EN: write 0x4000, wait 10 cycles, read -> value 10 (±1 for read latency); preload 0xFFFF -> wraps to 0.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants for the IO responder: address map, status bit positions and default TX FIFO depth.
package io_pkg;

    localparam logic [15:0] ADDR_LED         = 16'h1000;
    localparam logic [15:0] ADDR_UART_DATA   = 16'h2000;
    localparam logic [15:0] ADDR_UART_STATUS = 16'h2001;
    localparam logic [15:0] ADDR_TICK        = 16'h4000;

    localparam int STAT_TX_FULL    = 0;
    localparam int STAT_RX_AVAIL   = 1;
    localparam int STAT_RX_OVERRUN = 2;

    localparam int TX_DEPTH_DEFAULT = 4;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_LED,
        SEL_UART_DATA,
        SEL_UART_STATUS,
        SEL_TICK
    } io_sel_e;

    function automatic io_sel_e decode_addr(input logic [15:0] addr);
        case (addr)
            ADDR_LED:         return SEL_LED;
            ADDR_UART_DATA:   return SEL_UART_DATA;
            ADDR_UART_STATUS: return SEL_UART_STATUS;
            ADDR_TICK:        return SEL_TICK;
            default:          return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// Byte FIFO feeding the TX sink; registered storage, no fall-through, push accepted on full when a pop frees a slot.
module io_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/io_responder.sv
// IO responder: LED register, TX FIFO / RX byte port with status, and an optional tick counter
// (enabled by defining IO_TICK_COUNTER_EN).
module io_responder
    import io_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int TX_DEPTH = TX_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             io_rd,
    input  logic             io_wr,
    input  logic [15:0]      io_addr,
    input  logic [WIDTH-1:0] io_dout,
    output logic [WIDTH-1:0] io_din,
    output logic             io_ready,
    output logic [7:0]       leds,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid
);

    io_sel_e          sel;
    logic             tx_full, tx_empty, tx_pop, tx_push;
    logic             wr_en, rd_en, rx_read, stat_read;
    logic [WIDTH-1:0] rd_data, status, tick_val;

    logic [WIDTH-1:0] io_din_q, io_din_d;
    logic [7:0]       leds_q, leds_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_avail_q, rx_avail_d;
    logic             rx_overrun_q, rx_overrun_d;

    assign sel       = decode_addr(io_addr);
    assign tx_valid  = !tx_empty;
    assign tx_pop    = tx_valid && tx_ready;
    assign io_ready  = !(io_wr && (sel == SEL_UART_DATA) && tx_full && !tx_pop);
    assign wr_en     = io_wr && io_ready;
    assign rd_en     = io_rd && !io_wr;
    assign tx_push   = wr_en && (sel == SEL_UART_DATA);
    assign rx_read   = rd_en && (sel == SEL_UART_DATA);
    assign stat_read = rd_en && (sel == SEL_UART_STATUS);

    io_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .resetq    (resetq),
        .push      (tx_push),
        .push_data (io_dout[7:0]),
        .pop       (tx_pop),
        .pop_data  (tx_data),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    always_comb begin
        status                  = '0;
        status[STAT_TX_FULL]    = tx_full;
        status[STAT_RX_AVAIL]   = rx_avail_q;
        status[STAT_RX_OVERRUN] = rx_overrun_q;
        rd_data = '0;
        case (sel)
            SEL_LED:         rd_data = WIDTH'(leds_q);
            SEL_UART_DATA:   rd_data = WIDTH'(rx_byte_q);
            SEL_UART_STATUS: rd_data = status;
            SEL_TICK:        rd_data = tick_val;
            default:         rd_data = '0;
        endcase
    end

    // A new byte always lands; it only counts as an overrun if the old one was unread and not being read now.
    always_comb begin
        io_din_d     = rd_en ? rd_data : io_din_q;
        leds_d       = (wr_en && sel == SEL_LED) ? io_dout[7:0] : leds_q;
        rx_byte_d    = rx_valid ? rx_data : rx_byte_q;
        rx_avail_d   = rx_valid ? 1'b1 : (rx_read ? 1'b0 : rx_avail_q);
        rx_overrun_d = rx_overrun_q;
        if (rx_valid && rx_avail_q && !rx_read) rx_overrun_d = 1'b1;
        else if (stat_read)                     rx_overrun_d = 1'b0;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            io_din_q     <= '0;
            leds_q       <= '0;
            rx_byte_q    <= '0;
            rx_avail_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            io_din_q     <= io_din_d;
            leds_q       <= leds_d;
            rx_byte_q    <= rx_byte_d;
            rx_avail_q   <= rx_avail_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

`ifdef IO_TICK_COUNTER_EN
    logic [WIDTH-1:0] tick_q, tick_d;

    assign tick_d   = (wr_en && sel == SEL_TICK) ? '0 : tick_q + WIDTH'(1);
    assign tick_val = tick_q;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) tick_q <= '0;
        else         tick_q <= tick_d;
    end
`else
    assign tick_val = '0;
`endif

    assign io_din = io_din_q;
    assign leds   = leds_q;

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder: bus reads/writes, TX FIFO stall and ordering, RX status, reset.
module tb_io_responder;

    logic        clk = 1'b0;
    logic        resetq = 1'b0;
    logic        io_rd = 1'b0;
    logic        io_wr = 1'b0;
    logic [15:0] io_addr = '0;
    logic [15:0] io_dout = '0;
    logic [15:0] io_din;
    logic        io_ready;
    logic [7:0]  leds;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;

    int total = 0;
    int bad   = 0;

    io_responder #(.WIDTH(16), .TX_DEPTH(4)) dut (
        .clk      (clk),
        .resetq   (resetq),
        .io_rd    (io_rd),
        .io_wr    (io_wr),
        .io_addr  (io_addr),
        .io_dout  (io_dout),
        .io_din   (io_din),
        .io_ready (io_ready),
        .leds     (leds),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One bus cycle: drive strobes, take the edge, sample 1 time unit later.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] dout);
        io_rd   = rd;
        io_wr   = wr;
        io_addr = addr;
        io_dout = dout;
        @(posedge clk);
        #1;
        io_rd = 1'b0;
        io_wr = 1'b0;
    endtask

    task automatic rxPulse(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic drainCheck(input string tag, input logic [7:0] b);
        checkOutput({tag, "_valid"}, tx_valid, 1);
        checkOutput({tag, "_data"}, tx_data, b);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12 resetq = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_io_din", io_din, 0);
        checkOutput("rst_leds", leds, 0);
        checkOutput("rst_tx_valid", tx_valid, 0);
        checkOutput("rst_io_ready", io_ready, 1);

        applyStimulus(0, 1, 16'h1000, 16'h00A5);
        checkOutput("led_write", leds, 8'hA5);
        applyStimulus(1, 0, 16'h1000, 16'h0000);
        checkOutput("led_read", io_din, 16'h00A5);
        applyStimulus(1, 1, 16'h1000, 16'h005A);
        checkOutput("rdwr_led", leds, 8'h5A);
        checkOutput("rdwr_din_hold", io_din, 16'h00A5);
        applyStimulus(0, 1, 16'h3000, 16'h00FF);
        checkOutput("unmapped_wr", leds, 8'h5A);
        applyStimulus(1, 0, 16'h3000, 16'h0000);
        checkOutput("unmapped_rd", io_din, 0);
        applyStimulus(0, 0, 16'h0000, 16'h0000);
        checkOutput("din_hold_idle", io_din, 0);
        applyStimulus(1, 0, 16'h2001, 16'h0000);
        checkOutput("status_idle", io_din, 0);

        // Stall on full FIFO, then release via tx_ready
        tx_ready = 1'b0;
        io_wr = 1'b1; io_addr = 16'h2000; io_dout = 16'h0041;
        #1 checkOutput("nofallthru", tx_valid, 0);
        @(posedge clk);
        #1 io_wr = 1'b0;
        checkOutput("push_valid", tx_valid, 1);
        checkOutput("push_head", tx_data, 8'h41);
        applyStimulus(0, 1, 16'h2000, 16'h0042);
        applyStimulus(0, 1, 16'h2000, 16'h0043);
        applyStimulus(0, 1, 16'h2000, 16'h0044);
        applyStimulus(1, 0, 16'h2001, 16'h0000);
        checkOutput("status_full", io_din, 16'h0001);
        io_wr = 1'b1; io_addr = 16'h2000; io_dout = 16'h0045;
        #1 checkOutput("stall_ready", io_ready, 0);
        tx_ready = 1'b1;
        #1 checkOutput("unstall_ready", io_ready, 1);
        checkOutput("drain0_data", tx_data, 8'h41);
        @(posedge clk);
        #1 io_wr = 1'b0;
        drainCheck("drain1", 8'h42);
        drainCheck("drain2", 8'h43);
        drainCheck("drain3", 8'h44);
        drainCheck("drain4", 8'h45);
        checkOutput("drain_empty", tx_valid, 0);
        tx_ready = 1'b0;

        // Simultaneous push and pop on a full FIFO
        applyStimulus(0, 1, 16'h2000, 16'h0010);
        applyStimulus(0, 1, 16'h2000, 16'h0011);
        applyStimulus(0, 1, 16'h2000, 16'h0012);
        applyStimulus(0, 1, 16'h2000, 16'h0013);
        io_wr = 1'b1; io_addr = 16'h2000; io_dout = 16'h0055; tx_ready = 1'b1;
        #1 checkOutput("pushpop_ready", io_ready, 1);
        @(posedge clk);
        #1 io_wr = 1'b0; tx_ready = 1'b0;
        io_wr = 1'b1; io_dout = 16'h0066;
        #1 checkOutput("still_full", io_ready, 0);
        io_wr = 1'b0;
        tx_ready = 1'b1;
        #1;
        drainCheck("pp1", 8'h11);
        drainCheck("pp2", 8'h12);
        drainCheck("pp3", 8'h13);
        drainCheck("pp4", 8'h55);
        checkOutput("pp_empty", tx_valid, 0);
        tx_ready = 1'b0;

        // RX overrun and clearing
        rxPulse(8'h11);
        rxPulse(8'h22);
        applyStimulus(1, 0, 16'h2001, 16'h0000);
        checkOutput("rx_status_ovr", io_din, 16'h0006);
        applyStimulus(1, 0, 16'h2000, 16'h0000);
        checkOutput("rx_read_new", io_din, 16'h0022);
        applyStimulus(1, 0, 16'h2001, 16'h0000);
        checkOutput("rx_status_clr", io_din, 16'h0000);

        rxPulse(8'h22);
        rx_data = 8'h33; rx_valid = 1'b1;
        applyStimulus(1, 0, 16'h2000, 16'h0000);
        rx_valid = 1'b0;
        checkOutput("rx_coinc_old", io_din, 16'h0022);
        applyStimulus(1, 0, 16'h2000, 16'h0000);
        checkOutput("rx_coinc_new", io_din, 16'h0033);
        applyStimulus(1, 0, 16'h2001, 16'h0000);
        checkOutput("rx_coinc_noovr", io_din, 16'h0000);

        rxPulse(8'h44);
        rx_data = 8'h55; rx_valid = 1'b1;
        applyStimulus(1, 0, 16'h2001, 16'h0000);
        rx_valid = 1'b0;
        checkOutput("stat_pre_edge", io_din, 16'h0002);
        applyStimulus(1, 0, 16'h2001, 16'h0000);
        checkOutput("stat_set_wins", io_din, 16'h0006);
        applyStimulus(1, 0, 16'h2001, 16'h0000);
        checkOutput("stat_ovr_clr", io_din, 16'h0002);
        applyStimulus(1, 0, 16'h2000, 16'h0000);
        checkOutput("rx_last", io_din, 16'h0055);

`ifdef IO_TICK_COUNTER_EN
        applyStimulus(0, 1, 16'h4000, 16'h0000);
        repeat (10) @(posedge clk);
        #1;
        applyStimulus(1, 0, 16'h4000, 16'h0000);
        checkOutput("tick_10", io_din, 16'd10);
        applyStimulus(0, 1, 16'h4000, 16'h0000);
        repeat (65536) @(posedge clk);
        #1;
        applyStimulus(1, 0, 16'h4000, 16'h0000);
        checkOutput("tick_wrap", io_din, 16'h0000);
`else
        applyStimulus(0, 1, 16'h4000, 16'h1234);
        applyStimulus(1, 0, 16'h4000, 16'h0000);
        checkOutput("tick_absent", io_din, 16'h0000);
`endif

        // Reset mid-operation
        applyStimulus(0, 1, 16'h2000, 16'h0077);
        applyStimulus(0, 1, 16'h2000, 16'h0078);
        rxPulse(8'h99);
        applyStimulus(0, 1, 16'h1000, 16'h003C);
        applyStimulus(1, 0, 16'h1000, 16'h0000);
        checkOutput("pre_rst_din", io_din, 16'h003C);
        #2 resetq = 1'b0;
        #1;
        checkOutput("async_rst_din", io_din, 0);
        checkOutput("async_rst_leds", leds, 0);
        checkOutput("async_rst_tx", tx_valid, 0);
        @(negedge clk);
        resetq = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1, 0, 16'h2001, 16'h0000);
        checkOutput("post_rst_status", io_din, 16'h0000);
        checkOutput("post_rst_tx", tx_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
